// File: rtl/count_step_arbiter.sv
// count_step_arbiter: round-robin arbiter that lends a shared modulo-4 step
// counter to one requester at a time for a burst of Len steps, keeping a
// shadow of the counter value and pulsing Done to the requester at the end.
module count_step_arbiter #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*LEN_W-1:0] Len,
    output logic [NREQ-1:0]       Gnt,
    output logic                  Step,
    output logic [1:0]            Cnt,
    output logic [NREQ-1:0]       Done,
    output logic                  Busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  rem, rem_nx;
    logic [IW-1:0]     ptr, ptr_nx;
    logic [IW-1:0]     win, win_nx;
    logic [NREQ-1:0]   gnt_nx, done_nx;
    logic              step_nx, busy_nx;
    logic [1:0]        cnt_nx;

    logic              pick_vld;
    logic [IW-1:0]     pick, idx;
    logic [LEN_W-1:0]  pick_len;
    logic [NREQ-1:0]   pick_oh;

    // Round-robin pick: first requester at or after ptr, wrapping mod NREQ.
    // Walk offsets from the far end down so the nearest one is written last.
    always_comb begin
        pick_vld = 1'b0;
        pick     = ptr;
        idx      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (Req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
        pick_len = Len[int'(pick)*LEN_W +: LEN_W];
        pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << pick;
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        ptr_nx   = ptr;
        win_nx   = win;
        gnt_nx   = Gnt;
        step_nx  = 1'b0;
        done_nx  = '0;
        // Shadow follows the real counter: it advances on edges where the
        // counter saw its enable high.
        cnt_nx   = Step ? Cnt + 2'd1 : Cnt;
        case (state)
            IDLE: begin
                gnt_nx = '0;
                if (pick_vld) begin
                    win_nx = pick;
                    gnt_nx = pick_oh;
                    rem_nx = pick_len;
                    if (pick_len != '0) begin
                        state_nx = RUN;
                        step_nx  = 1'b1;
                    end else begin
                        // Zero-length burst: straight to completion.
                        state_nx = DONE;
                        done_nx  = pick_oh;
                    end
                end
            end
            RUN: begin
                rem_nx = rem - 1'b1;
                if (rem == LEN_W'(1)) begin
                    state_nx = DONE;
                    done_nx  = Gnt;
                end else begin
                    step_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                // Winner drops to lowest priority for the next round.
                ptr_nx   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            rem   <= '0;
            ptr   <= '0;
            win   <= '0;
            Gnt   <= '0;
            Step  <= 1'b0;
            Cnt   <= 2'd0;
            Done  <= '0;
            Busy  <= 1'b0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            ptr   <= ptr_nx;
            win   <= win_nx;
            Gnt   <= gnt_nx;
            Step  <= step_nx;
            Cnt   <= cnt_nx;
            Done  <= done_nx;
            Busy  <= busy_nx;
        end
    end

endmodule
